// File: rtl/mul_div_if.sv
// mul_div_if: request/response bundle between the execute-stage controller
// and the iterative RV32M multiply/divide unit.
//   Start  : request, sampled by the unit only while it is idle (IDLE/DONE)
//   funct  : RV32M funct3 selecting the operation
//   A, B   : rs1 / rs2 operands (dividend/multiplicand, divisor/multiplier)
//   Busy   : operation in progress, controller stalls while high
//   Done   : one-cycle pulse, Out is valid in that cycle
//   Out    : registered result, held until the next accepted request completes
// master = issuing controller, slave = mul_div_unit.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Out;

  modport master (
    output Start, funct, A, B,
    input  Busy, Done, Out
  );

  modport slave (
    input  Start, funct, A, B,
    output Busy, Done, Out
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit with a fixed 35-cycle
// latency (Start edge to Done cycle inclusive) for every opcode and operand.
// Ports:
//   Clock   : rising-edge clock
//   Reset_n : synchronous active-low reset, aborts any operation in flight
//   bus     : mul_div_if.slave (Start, funct, A, B in; Busy, Done, Out out)
// Flow: IDLE -> PREP (magnitudes/signs) -> CALC (32 radix-2 steps)
//       -> FIX (sign fix-up, special cases, load Out) -> DONE (Done pulse).
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      Clock,
  input  logic      Reset_n,
  mul_div_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement negate when requested (result width).
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Two's-complement negate when requested (double-width product).
  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t             state_r, next_state_s;
  logic [WIDTH-1:0]   a_r, b_r, opnd_r, out_r;
  logic [2:0]         funct_r;
  logic [2*WIDTH-1:0] prod_r;       // product, or {unused, dividend->quotient} when dividing
  logic [WIDTH:0]     rem_r;        // partial remainder
  logic [4:0]         cnt_r;
  logic               neg_res_r, neg_rem_r, div_zero_r, ovf_r;
  logic               busy_r, done_r;

  logic               accept_s, is_div_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s, div_fit_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, quo_fix_s, rem_fix_s, result_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH+1:0]   div_trial_s;
  logic [2*WIDTH-1:0] prod_fix_s;

  // Operand signedness per opcode (MULHSU: only A signed; MUL low half is sign-agnostic).
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (funct_r)
      F_MULH, F_DIV, F_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      F_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      F_MUL, F_MULHU, F_DIVU, F_REMU: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
  end

  assign is_div_s = funct_r[2];
  assign a_neg_s  = a_signed_s & a_r[WIDTH-1];
  assign b_neg_s  = b_signed_s & b_r[WIDTH-1];
  assign a_mag_s  = cond_neg(a_r, a_neg_s);
  assign b_mag_s  = cond_neg(b_r, b_neg_s);

  // One shift-add step: add multiplicand into upper half when multiplier LSB is set.
  assign mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
  // One restoring step: shift next dividend bit into the remainder and trial-subtract.
  assign div_trial_s = {rem_r, prod_r[WIDTH-1]} - {2'b00, opnd_r};
  assign div_fit_s   = ~div_trial_s[WIDTH+1];

  assign prod_fix_s = cond_neg2(prod_r, neg_res_r);
  assign quo_fix_s  = cond_neg(prod_r[WIDTH-1:0], neg_res_r);
  assign rem_fix_s  = cond_neg(rem_r[WIDTH-1:0], neg_rem_r);

  // Result selection including forced divide-by-zero and signed-overflow values.
  always_comb begin
    result_s = ZERO_W;
    case (funct_r)
      F_MUL: result_s = prod_fix_s[WIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU: result_s = prod_fix_s[2*WIDTH-1:WIDTH];
      F_DIV, F_DIVU: begin
        if (div_zero_r) begin
          result_s = ONES_W;
        end else if (ovf_r) begin
          result_s = MIN_W;
        end else begin
          result_s = quo_fix_s;
        end
      end
      F_REM, F_REMU: begin
        if (div_zero_r) begin
          result_s = a_r;
        end else if (ovf_r) begin
          result_s = ZERO_W;
        end else begin
          result_s = rem_fix_s;
        end
      end
      default: result_s = ZERO_W;
    endcase
  end

  // Requests are only taken when nothing is in flight.
  always_comb begin
    if ((state_r == IDLE) || (state_r == DONE)) begin
      accept_s = bus.Start;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = PREP;
        else          next_state_s = IDLE;
      end
      PREP: next_state_s = CALC;
      CALC: begin
        if (cnt_r == 5'(WIDTH-1)) next_state_s = FIX;
        else                      next_state_s = CALC;
      end
      FIX:  next_state_s = DONE;
      DONE: begin
        if (accept_s) next_state_s = PREP;
        else          next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset_n) state_r <= IDLE;
    else          state_r <= next_state_s;
  end

  // Registered status: derived from the next state so they line up with the state.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == PREP) || (next_state_s == CALC) || (next_state_s == FIX);
      done_r <= (next_state_s == DONE);
    end
  end

  // Datapath: operand latch, preparation, iteration and result load.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      a_r        <= ZERO_W;
      b_r        <= ZERO_W;
      funct_r    <= 3'b000;
      opnd_r     <= ZERO_W;
      prod_r     <= {(2*WIDTH){1'b0}};
      rem_r      <= {(WIDTH+1){1'b0}};
      cnt_r      <= 5'd0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      ovf_r      <= 1'b0;
      out_r      <= ZERO_W;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            funct_r <= bus.funct;
          end
        end
        PREP: begin
          // Multiply: opnd = multiplicand, prod low = multiplier.
          // Divide:   opnd = divisor,      prod low = dividend (becomes quotient).
          opnd_r     <= is_div_s ? b_mag_s : a_mag_s;
          prod_r     <= {ZERO_W, (is_div_s ? a_mag_s : b_mag_s)};
          rem_r      <= {(WIDTH+1){1'b0}};
          cnt_r      <= 5'd0;
          neg_res_r  <= a_neg_s ^ b_neg_s;
          neg_rem_r  <= a_neg_s;
          div_zero_r <= is_div_s && (b_r == ZERO_W);
          ovf_r      <= is_div_s && b_signed_s && (a_r == MIN_W) && (b_r == ONES_W);
        end
        CALC: begin
          cnt_r <= cnt_r + 5'd1;
          if (is_div_s) begin
            rem_r  <= div_fit_s ? div_trial_s[WIDTH:0] : {rem_r[WIDTH-1:0], prod_r[WIDTH-1]};
            prod_r <= {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-2:0], div_fit_s};
          end else begin
            prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
          end
        end
        FIX: out_r <= result_s;
        default: out_r <= out_r;
      endcase
    end
  end

  assign bus.Busy = busy_r;
  assign bus.Done = done_r;
  assign bus.Out  = out_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: reset, multiply/divide
// vectors issued back-to-back, divide corner cases, ignored Start while
// busy and reset in the middle of an operation.
module tb_mul_div_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mul_div_if #(.WIDTH(32)) io ();

  mul_div_unit #(.WIDTH(32)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when it does not match.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request (unit must be idle or in DONE), scramble the inputs
  // afterwards, wait for Done and check latency and result.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    bit seen;
    io.Start = 1'b1;
    io.funct = f;
    io.A     = a;
    io.B     = b;
    @(posedge clk); #1;
    io.Start = 1'b0;
    io.A     = $urandom();
    io.B     = $urandom();
    io.funct = 3'($urandom());
    check_eq({tag, "_busy"}, 32'(io.Busy), 32'd1);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (io.Done) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd35);
    check_eq({tag, "_out"}, io.Out, exp);
  endtask

  initial begin
    int cyc;
    int ndone;
    int first_lat;
    logic [31:0] first_out;

    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    io.Start = 1'b0;
    io.funct = 3'b000;
    io.A     = 32'h0000_0000;
    io.B     = 32'h0000_0000;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_busy", 32'(io.Busy), 32'd0);
    check_eq("rst_done", 32'(io.Done), 32'd0);
    check_eq("rst_out",  io.Out, 32'h0000_0000);
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (io.Done) ndone++;
    end
    check_eq("idle_no_done", 32'(ndone), 32'd0);

    // Multiplies, divides and corners, each issued in the DONE cycle of the previous.
    run_op("mul",    F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh",   F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu",  F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div",    F_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    run_op("rem",    F_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op("divu",   F_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC);
    run_op("remu",   F_REMU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001);
    run_op("divu0",  F_DIVU,   32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF);
    run_op("rem0",   F_REM,    32'h0000_1234, 32'h0000_0000, 32'h0000_1234);
    run_op("divovf", F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("removf", F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Done is a single-cycle pulse; with no new Start the unit goes idle.
    @(posedge clk); #1;
    check_eq("pulse_done", 32'(io.Done), 32'd0);
    check_eq("pulse_busy", 32'(io.Busy), 32'd0);

    // Start while busy is ignored.
    io.Start = 1'b1;
    io.funct = F_DIV;
    io.A     = 32'd100;
    io.B     = 32'd7;
    @(posedge clk); #1;
    io.Start  = 1'b0;
    cyc       = 1;
    ndone     = 0;
    first_lat = 0;
    first_out = 32'h0000_0000;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (io.Done) begin
        ndone++;
        if (ndone == 1) begin
          first_lat = cyc;
          first_out = io.Out;
        end
      end
      if (cyc == 10) begin
        io.Start = 1'b1;
        io.funct = F_MUL;
        io.A     = 32'd3;
        io.B     = 32'd3;
      end else begin
        io.Start = 1'b0;
      end
    end
    check_eq("ign_ndone", 32'(ndone), 32'd1);
    check_eq("ign_lat",   32'(first_lat), 32'd35);
    check_eq("ign_out",   first_out, 32'h0000_000E);

    // Reset in the middle of a multiply aborts it.
    io.Start = 1'b1;
    io.funct = F_MUL;
    io.A     = 32'd5;
    io.B     = 32'd5;
    @(posedge clk); #1;
    io.Start = 1'b0;
    cyc      = 1;
    ndone    = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (io.Done) ndone++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("abort_busy", 32'(io.Busy), 32'd0);
    check_eq("abort_out",  io.Out, 32'h0000_0000);
    check_eq("abort_done", 32'(io.Done), 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (io.Done) ndone++;
    end
    check_eq("abort_no_done", 32'(ndone), 32'd0);
    run_op("mul_after", F_MUL, 32'd5, 32'd5, 32'h0000_0019);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
